sw_debounce_pulse: RTL and testbench

- Input conditioning stage that sits directly upstream of the LFSR/seven-segment display logic.
- Takes the raw board switch/button bus, synchronizes it into the `clk` domain, and rejects bounce and glitches.
- Delivers clean debounced levels plus single-cycle rise/fall pulses.
- Downstream logic uses these as clock enables (e.g. LFSR step on `sw_rise[8]`, seed load on `sw_level[9]`), so it no longer uses a switch as a clock.

---
 rtl/sw_debounce_pulse.sv | 127 ++++++++++++
 tb/tb_sw_debounce_pulse.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_debounce_pulse.sv
// Synchronizes and debounces a bus of raw switch/button levels. Each channel
// gets clean levels plus single-cycle rise/fall pulses usable as clock enables.
module sw_debounce_pulse #(
    parameter int WIDTH         = 10,
    parameter int CNT_W         = 16,
    parameter int STABLE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_level,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             busy
);

    if (STABLE_CYCLES < 2 || longint'(STABLE_CYCLES) > ((64'd1 << CNT_W) - 64'd1)) begin : g_bad_stable
        $error("sw_debounce_pulse: STABLE_CYCLES out of range for CNT_W");
    end

    typedef enum logic [1:0] {
        S_LOW    = 2'd0,
        S_WAIT_H = 2'd1,
        S_HIGH   = 2'd2,
        S_WAIT_L = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Per-channel FSM state and counter; state_q is the debug view of each FSM.
    state_t           state_q [WIDTH];
    state_t           state_d [WIDTH];
    logic [CNT_W-1:0] cnt_q   [WIDTH];
    logic [CNT_W-1:0] cnt_d   [WIDTH];

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] level_d;
    logic [WIDTH-1:0] rise_d;
    logic [WIDTH-1:0] fall_d;
    logic             busy_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            sw_level <= '0;
            sw_rise  <= '0;
            sw_fall  <= '0;
            busy     <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= S_LOW;
                cnt_q[i]   <= '0;
            end
        end else begin
            sync1    <= sw_raw;
            sync2    <= sync1;
            sw_level <= level_d;
            sw_rise  <= rise_d;
            sw_fall  <= fall_d;
            busy     <= busy_d;
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Outputs are derived from the next state so they register alongside it.
    always_comb begin
        level_d = '0;
        rise_d  = '0;
        fall_d  = '0;
        busy_d  = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                S_LOW: begin
                    cnt_d[i] = '0;
                    if (sync2[i]) begin
                        state_d[i] = S_WAIT_H;
                        cnt_d[i]   = CNT_ONE;
                    end
                end
                S_WAIT_H: begin
                    if (!sync2[i]) begin
                        state_d[i] = S_LOW;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = S_HIGH;
                        cnt_d[i]   = '0;
                        rise_d[i]  = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                S_HIGH: begin
                    if (!sync2[i]) begin
                        state_d[i] = S_WAIT_L;
                        cnt_d[i]   = CNT_ONE;
                    end
                end
                S_WAIT_L: begin
                    if (sync2[i]) begin
                        state_d[i] = S_HIGH;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = S_LOW;
                        cnt_d[i]   = '0;
                        fall_d[i]  = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                default: begin
                    state_d[i] = S_LOW;
                    cnt_d[i]   = '0;
                end
            endcase
            level_d[i] = (state_d[i] == S_HIGH) || (state_d[i] == S_WAIT_L);
            busy_d     = busy_d || (state_d[i] == S_WAIT_H) || (state_d[i] == S_WAIT_L);
        end
    end

endmodule

// File: tb/tb_sw_debounce_pulse.sv
// Bench for sw_debounce_pulse: a run-length reference model queues the expected
// {level, rise, fall, busy} per edge, and each scenario task pops and compares.
module tb_sw_debounce_pulse;

    localparam int WIDTH  = 10;
    localparam int STABLE = 4;
    localparam int OUT_W  = 3 * WIDTH + 1;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] sw_level;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
    logic             busy;

    sw_debounce_pulse #(
        .WIDTH        (WIDTH),
        .CNT_W        (16),
        .STABLE_CYCLES(STABLE)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sw_raw  (sw_raw),
        .sw_level(sw_level),
        .sw_rise (sw_rise),
        .sw_fall (sw_fall),
        .busy    (busy)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard
    logic [OUT_W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a channel flips once STABLE consecutive synchronized
    // samples disagree with its current level.
    logic [WIDTH-1:0] m_s1, m_s2, m_level;
    int               m_run [WIDTH];

    task automatic drive_cycle(input logic r, input logic [WIDTH-1:0] raw);
        logic [WIDTH-1:0] rise, fall;
        logic             bsy;
        @(negedge clk);
        rst    = r;
        sw_raw = raw;
        rise   = '0;
        fall   = '0;
        bsy    = 1'b0;
        if (r) begin
            m_s1 = '0;
            m_s2 = '0;
            m_level = '0;
            for (int i = 0; i < WIDTH; i++) m_run[i] = 0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (m_s2[i] != m_level[i]) begin
                    m_run[i]++;
                    if (m_run[i] == STABLE) begin
                        m_level[i] = ~m_level[i];
                        if (m_level[i]) rise[i] = 1'b1;
                        else            fall[i] = 1'b1;
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
                if (m_run[i] != 0) bsy = 1'b1;
            end
            m_s2 = m_s1;
            m_s1 = raw;
        end
        exp_q.push_back({m_level, rise, fall, bsy});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [OUT_W-1:0] exp;
        drive_cycle(1'b1, '0);
        drive_cycle(1'b1, '0);
        for (int k = 0; k < 20; k++) drive_cycle(1'b0, '0);
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            n_cmp++;
            if ({sw_level, sw_rise, sw_fall, busy} !== exp) begin
                n_bad++;
                $display("FAIL reset_idle got=%h exp=%h", {sw_level, sw_rise, sw_fall, busy}, exp);
            end
            if (exp_q.size() > 0) break;
        end
        n_cmp++;
        if ({sw_level, sw_rise, sw_fall, busy} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs got=%h exp=0", {sw_level, sw_rise, sw_fall, busy});
        end
        while (exp_q.size() > 0) void'(exp_q.pop_front());
    endtask

    task automatic test_step();
        logic [OUT_W-1:0] exp;
        int rise_at, fall_at, busy_at;
        rise_at = -1; fall_at = -1; busy_at = -1;
        for (int k = 0; k < 8; k++) begin
            drive_cycle(1'b0, 10'h100);
            exp = exp_q.pop_front();
            n_cmp++;
            if ({sw_level, sw_rise, sw_fall, busy} !== exp) begin
                n_bad++;
                $display("FAIL step_rise cyc=%0d got=%h exp=%h", k, {sw_level, sw_rise, sw_fall, busy}, exp);
            end
            if (busy && busy_at < 0) busy_at = k;
            if (sw_rise[8] && rise_at < 0) rise_at = k;
        end
        n_cmp++;
        if (rise_at !== 5 || busy_at !== 2) begin
            n_bad++;
            $display("FAIL step_latency rise_at=%0d busy_at=%0d exp rise_at=5 busy_at=2", rise_at, busy_at);
        end
        for (int k = 0; k < 8; k++) begin
            drive_cycle(1'b0, 10'h000);
            exp = exp_q.pop_front();
            n_cmp++;
            if ({sw_level, sw_rise, sw_fall, busy} !== exp) begin
                n_bad++;
                $display("FAIL step_fall cyc=%0d got=%h exp=%h", k, {sw_level, sw_rise, sw_fall, busy}, exp);
            end
            if (sw_fall[8] && fall_at < 0) fall_at = k;
        end
        n_cmp++;
        if (fall_at !== 5) begin
            n_bad++;
            $display("FAIL step_fall_latency got=%0d exp=5", fall_at);
        end
    endtask

    task automatic test_bounce();
        logic [OUT_W-1:0] exp;
        logic [14:0]      pat;
        int               rises, changes;
        logic             prev;
        pat = 15'b111111_111101101;
        rises = 0; changes = 0; prev = sw_level[8];
        for (int k = 0; k < 15; k++) begin
            drive_cycle(1'b0, {1'b0, pat[k], 8'h00});
            exp = exp_q.pop_front();
            n_cmp++;
            if ({sw_level, sw_rise, sw_fall, busy} !== exp) begin
                n_bad++;
                $display("FAIL bounce cyc=%0d got=%h exp=%h", k, {sw_level, sw_rise, sw_fall, busy}, exp);
            end
            if (sw_rise[8]) rises++;
            if (sw_level[8] != prev) changes++;
            prev = sw_level[8];
        end
        n_cmp++;
        if (rises !== 1 || changes !== 1 || sw_level[8] !== 1'b1) begin
            n_bad++;
            $display("FAIL bounce_count rises=%0d changes=%0d level=%b exp 1/1/1", rises, changes, sw_level[8]);
        end
        for (int k = 0; k < 8; k++) begin
            drive_cycle(1'b0, '0);
            void'(exp_q.pop_front());
        end
    endtask

    task automatic test_glitch();
        logic [OUT_W-1:0] exp;
        int               pulses;
        logic             base;
        pulses = 0;
        for (int phase = 0; phase < 2; phase++) begin
            base = (phase == 1);
            for (int k = 0; k < 8; k++) begin
                drive_cycle(1'b0, {6'b0, base, 3'b0});
                void'(exp_q.pop_front());
            end
            pulses = 0;
            for (int len = 1; len <= 3; len++) begin
                for (int k = 0; k < len + 6; k++) begin
                    drive_cycle(1'b0, {6'b0, (k < len) ? ~base : base, 3'b0});
                    exp = exp_q.pop_front();
                    n_cmp++;
                    if ({sw_level, sw_rise, sw_fall, busy} !== exp) begin
                        n_bad++;
                        $display("FAIL glitch ph=%0d len=%0d cyc=%0d got=%h exp=%h", phase, len, k, {sw_level, sw_rise, sw_fall, busy}, exp);
                    end
                    if (sw_rise[3] || sw_fall[3] || sw_level[3] != base) pulses++;
                end
            end
            n_cmp++;
            if (pulses !== 0) begin
                n_bad++;
                $display("FAIL glitch_quiet ph=%0d got=%0d exp=0", phase, pulses);
            end
        end
        for (int k = 0; k < 8; k++) begin
            drive_cycle(1'b0, '0);
            void'(exp_q.pop_front());
        end
    endtask

    task automatic test_simultaneous();
        logic [OUT_W-1:0] exp;
        logic [WIDTH-1:0] rise_seen;
        rise_seen = '0;
        for (int k = 0; k < 8; k++) begin
            drive_cycle(1'b0, 10'h201);
            exp = exp_q.pop_front();
            n_cmp++;
            if ({sw_level, sw_rise, sw_fall, busy} !== exp) begin
                n_bad++;
                $display("FAIL simul cyc=%0d got=%h exp=%h", k, {sw_level, sw_rise, sw_fall, busy}, exp);
            end
            if (k == 5) rise_seen = sw_rise;
        end
        n_cmp++;
        if (rise_seen !== 10'h201 || sw_level !== 10'h201) begin
            n_bad++;
            $display("FAIL simul_pulse rise=%h level=%h exp 201/201", rise_seen, sw_level);
        end
        for (int k = 0; k < 8; k++) begin
            drive_cycle(1'b0, '0);
            void'(exp_q.pop_front());
        end
    endtask

    task automatic test_reset_midcount();
        logic [OUT_W-1:0] exp;
        int               rise_at;
        rise_at = -1;
        // Edges 0..3: raw[5] sampled at edge 0, channel in WAIT_H with cnt=2 after edge 3.
        for (int k = 0; k < 4; k++) begin
            drive_cycle(1'b0, 10'h020);
            void'(exp_q.pop_front());
        end
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL midcount_busy got=%b exp=1", busy);
        end
        drive_cycle(1'b1, 10'h020);
        exp = exp_q.pop_front();
        n_cmp++;
        if ({sw_level, sw_rise, sw_fall, busy} !== exp) begin
            n_bad++;
            $display("FAIL midcount_reset got=%h exp=%h", {sw_level, sw_rise, sw_fall, busy}, exp);
        end
        for (int k = 0; k < 8; k++) begin
            drive_cycle(1'b0, 10'h020);
            exp = exp_q.pop_front();
            n_cmp++;
            if ({sw_level, sw_rise, sw_fall, busy} !== exp) begin
                n_bad++;
                $display("FAIL post_reset cyc=%0d got=%h exp=%h", k, {sw_level, sw_rise, sw_fall, busy}, exp);
            end
            if (sw_rise[5] && rise_at < 0) rise_at = k;
        end
        n_cmp++;
        if (rise_at !== 5) begin
            n_bad++;
            $display("FAIL post_reset_latency got=%0d exp=5", rise_at);
        end
    endtask

    task automatic test_random();
        logic [OUT_W-1:0] exp;
        logic [WIDTH-1:0] raw;
        raw = '0;
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 3) == 0) raw = raw ^ WIDTH'($urandom_range(0, 1023));
            drive_cycle(1'b0, raw);
            exp = exp_q.pop_front();
            n_cmp++;
            if ({sw_level, sw_rise, sw_fall, busy} !== exp) begin
                n_bad++;
                $display("FAIL random cyc=%0d got=%h exp=%h", k, {sw_level, sw_rise, sw_fall, busy}, exp);
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        sw_raw = '0;
        m_s1 = '0; m_s2 = '0; m_level = '0;
        for (int i = 0; i < WIDTH; i++) m_run[i] = 0;
        test_reset();
        test_step();
        test_bounce();
        test_glitch();
        test_simultaneous();
        test_reset_midcount();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
